// File: rtl/gerador_comandos_rpn.sv
// ============================================================================
// Module   : gerador_comandos_rpn
// Purpose  : Input-side command producer for the RPN calculator. Synchronises
//            and debounces the board keys/switches, turns each press into one
//            command and delivers commands over a valid/ready handshake.
// Revision : 1.0 - initial release
//
// Ports
//   clk         system clock
//   rst         asynchronous active-high reset
//   key_n[1:0]  raw push-buttons, active-low ([0] enter number, [1] enter op)
//   sw[9:0]     raw switches ([7:0] operand, [2:0] opcode, [9] execute)
//   cmd_valid   command available
//   cmd_ready   consumer accepts command
//   cmd_tipo    00 none, 01 PUSH, 10 OP, 11 EXEC
//   cmd_dado    PUSH: operand, OP: {5'b0, opcode}, EXEC: 8'h00
//   descartado  sticky flag: an event was lost
//
// Build option
//   CMD_FIFO_EN  defined   : output stage is a 4-entry FIFO (1 command/cycle)
//                undefined : output stage is a single hold register
// ============================================================================
`default_nettype none

module gerador_comandos_rpn #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] key_n,
   input  logic [9:0] sw,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [1:0] cmd_tipo,
   output logic [7:0] cmd_dado,
   output logic       descartado
);

   localparam int            CW        = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   // Released level of each debounced source: {sw9, key1, key0}
   localparam logic [2:0]    REL_LEVEL = 3'b011;
   localparam logic [1:0]    TIPO_PUSH = 2'b01;
   localparam logic [1:0]    TIPO_OP   = 2'b10;
   localparam logic [1:0]    TIPO_EXEC = 2'b11;

   // ------------------------------------------------------------------------
   // Two-flop synchronisers; keys reset to released (high)
   // ------------------------------------------------------------------------
   logic [1:0] key_meta, key_sync;
   logic [9:0] sw_meta, sw_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_meta <= 2'b11;
         key_sync <= 2'b11;
         sw_meta  <= '0;
         sw_sync  <= '0;
      end else begin
         key_meta <= key_n;
         key_sync <= key_meta;
         sw_meta  <= sw;
         sw_sync  <= sw_meta;
      end
   end

   // sw[8] is synchronised with the rest of the bus but has no function
   wire unused_sw8 = sw_sync[8];

   // ------------------------------------------------------------------------
   // Debouncers for key0, key1 and sw9
   // ------------------------------------------------------------------------
   logic [2:0]    db_in;
   logic [2:0]    stable;
   logic [CW-1:0] cnt [3];
   logic [2:0]    flip;
   logic [2:0]    press;

   assign db_in = {sw_sync[9], key_sync};

   // The flip happens on the cycle that brings the mismatch run to
   // DEBOUNCE_CYCLES, i.e. when the counter already holds DEBOUNCE_CYCLES-1.
   always_comb begin
      flip = '0;
      for (int i = 0; i < 3; i++) begin
         flip[i] = (db_in[i] != stable[i]) && (cnt[i] == CNT_LAST);
      end
   end

   // A press is a flip away from the released level
   assign press = flip & ~(stable ^ REL_LEVEL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable <= REL_LEVEL;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (db_in[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (flip[i]) begin
               stable[i] <= ~stable[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Event register: data captured from the synchronised switches on the
   // flip cycle
   // ------------------------------------------------------------------------
   logic [2:0] ev;
   logic [7:0] ev_push_data, ev_op_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ev           <= '0;
         ev_push_data <= '0;
         ev_op_data   <= '0;
      end else begin
         ev <= press;
         if (press[0]) ev_push_data <= sw_sync[7:0];
         if (press[1]) ev_op_data   <= {5'b0, sw_sync[2:0]};
      end
   end

   // ------------------------------------------------------------------------
   // Pending stage and drop detection
   // ------------------------------------------------------------------------
   logic [2:0] pend;
   logic [2:0] grant;
   logic [2:0] drop;
   logic [7:0] pend_push_data, pend_op_data;

   // Occupancy is judged at the start of the cycle, so an event meeting its
   // own pend bit is lost even if that bit is being granted this cycle.
   assign drop = ev & pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend           <= '0;
         pend_push_data <= '0;
         pend_op_data   <= '0;
         descartado     <= 1'b0;
      end else begin
         pend <= (pend & ~grant) | (ev & ~pend);
         if (ev[0] && !pend[0]) pend_push_data <= ev_push_data;
         if (ev[1] && !pend[1]) pend_op_data   <= ev_op_data;
         if (|drop) descartado <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Fixed-priority arbiter PUSH > OP > EXEC
   // ------------------------------------------------------------------------
   logic       space;
   logic [9:0] grant_word;

   always_comb begin
      grant      = '0;
      grant_word = '0;
      if (space) begin
         if (pend[0]) begin
            grant      = 3'b001;
            grant_word = {TIPO_PUSH, pend_push_data};
         end else if (pend[1]) begin
            grant      = 3'b010;
            grant_word = {TIPO_OP, pend_op_data};
         end else if (pend[2]) begin
            grant      = 3'b100;
            grant_word = {TIPO_EXEC, 8'h00};
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output stage
   // ------------------------------------------------------------------------
   logic       out_valid;
   logic [9:0] out_word;

`ifdef CMD_FIFO_EN
   logic [9:0] fifo_mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] count;
   logic       do_push, do_pop;

   // Space is taken from the registered count: a pop in the same cycle
   // does not let a full FIFO accept.
   assign space     = (count != 3'd4);
   assign do_push   = |grant;
   assign do_pop    = out_valid & cmd_ready;
   assign out_valid = (count != 3'd0);
   assign out_word  = fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) fifo_mem[wr_ptr] <= grant_word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {2'b0, do_push} - {2'b0, do_pop};
      end
   end
`else
   logic       hold_valid;
   logic [9:0] hold_word;

   // Loads only when empty at the start of the cycle, hence one command
   // every two cycles at best.
   assign space     = !hold_valid;
   assign out_valid = hold_valid;
   assign out_word  = hold_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid <= 1'b0;
         hold_word  <= '0;
      end else if (|grant) begin
         hold_valid <= 1'b1;
         hold_word  <= grant_word;
      end else if (hold_valid && cmd_ready) begin
         hold_valid <= 1'b0;
      end
   end
`endif

   assign cmd_valid = out_valid;
   assign cmd_tipo  = out_valid ? out_word[9:8] : 2'b00;
   assign cmd_dado  = out_valid ? out_word[7:0] : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_gerador_comandos_rpn.sv
`default_nettype none

module tb_gerador_comandos_rpn;

   localparam int DB = 4;

`ifdef CMD_FIFO_EN
   localparam logic EXP_DROP = 1'b0;
`else
   localparam logic EXP_DROP = 1'b1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] key_n;
   logic [9:0] sw;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_tipo;
   logic [7:0] cmd_dado;
   logic       descartado;

   logic ready_hi   = 1'b0;
   logic ready_rand = 1'b0;
   logic rnd_bit    = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   logic [9:0] got[$];
   logic [9:0] exp_q[$];

   gerador_comandos_rpn #(.DEBOUNCE_CYCLES(DB)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_n      (key_n),
      .sw         (sw),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_tipo   (cmd_tipo),
      .cmd_dado   (cmd_dado),
      .descartado (descartado)
   );

   always #5 clk = ~clk;

   assign cmd_ready = ready_hi | (ready_rand & rnd_bit);

   always @(posedge clk) begin
      #1 rnd_bit = 1'($urandom_range(0, 1));
   end

   // Record every accepted command, sampled away from the active edge
   always @(negedge clk) begin
      if (!rst && cmd_valid && cmd_ready) got.push_back({cmd_tipo, cmd_dado});
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Press-and-release one source: 0 key0, 1 key1, 2 sw9
   task automatic press(input int src, input int hold);
      if (src == 2) sw[9] = 1'b1; else key_n[src] = 1'b0;
      step(hold);
      if (src == 2) sw[9] = 1'b0; else key_n[src] = 1'b1;
      step(hold);
   endtask

   task automatic glitch(input int src, input int len);
      if (src == 2) sw[9] = 1'b1; else key_n[src] = 1'b0;
      step(len);
      if (src == 2) sw[9] = 1'b0; else key_n[src] = 1'b1;
      step(8);
   endtask

   // Wait (bounded) for the expected stream, then compare it in order
   task automatic drain(input string tag);
      int budget = 400;
      while (got.size() < exp_q.size() && budget > 0) begin
         step(1);
         budget--;
      end
      step(12);
      check({tag, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check(tag, 32'(got[i]), 32'(exp_q[i]));
      got.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [9:0] stim;
      int act;

      rst   = 1'b1;
      key_n = 2'b11;
      sw    = '0;
      step(3);
      @(negedge clk);
      check("rst_valid", cmd_valid, 0);
      check("rst_tipo", cmd_tipo, 0);
      check("rst_dado", cmd_dado, 0);
      check("rst_desc", descartado, 0);
      step(1);
      rst = 1'b0;
      step(10);

      // Clean press: valid at edge DB+4 for exactly one cycle
      ready_hi = 1'b1;
      sw = 10'h02A;
      step(4);
      key_n[0] = 1'b0;
      repeat (DB + 3) @(posedge clk);
      @(negedge clk);
      check("lat_early", cmd_valid, 0);
      @(negedge clk);
      check("lat_valid", cmd_valid, 1);
      check("lat_tipo", cmd_tipo, 2'b01);
      check("lat_dado", cmd_dado, 8'h2A);
      @(negedge clk);
      check("lat_gone", cmd_valid, 0);
      step(10);
      key_n[0] = 1'b1;
      step(15);
      exp_q.push_back({2'b01, 8'h2A});
      drain("clean");

      // Bounce on key1: 3-cycle pulses never qualify
      sw = 10'h0AD;
      step(4);
      for (int i = 0; i < 5; i++) begin
         key_n[1] = 1'b0;
         step(3);
         key_n[1] = 1'b1;
         step(3);
      end
      key_n[1] = 1'b0;
      step(15);
      key_n[1] = 1'b1;
      step(15);
      exp_q.push_back({2'b10, 8'h05});
      drain("bounce");

      // Simultaneous key0, key1, sw9
      sw = 10'h05D;
      step(4);
      key_n = 2'b00;
      sw[9] = 1'b1;
      step(15);
      key_n = 2'b11;
      sw[9] = 1'b0;
      step(15);
      exp_q.push_back({2'b01, 8'h5D});
      exp_q.push_back({2'b10, 8'h05});
      exp_q.push_back({2'b11, 8'h00});
      drain("simul");
      check("simul_desc", descartado, 0);

      // Backpressure: output held while cmd_ready is low
      ready_hi = 1'b0;
      sw = 10'h011;
      step(4);
      press(0, 10);
      check("bp_valid", cmd_valid, 1);
      check("bp_tipo", cmd_tipo, 2'b01);
      check("bp_dado1", cmd_dado, 8'h11);
      sw = 10'h022;
      step(4);
      press(0, 10);
      check("bp_dado2", cmd_dado, 8'h11);
      sw = 10'h033;
      step(4);
      press(0, 10);
      check("bp_desc", descartado, EXP_DROP);
      step(30);
      check("bp_hold_valid", cmd_valid, 1);
      check("bp_hold_dado", cmd_dado, 8'h11);
      exp_q.push_back({2'b01, 8'h11});
      exp_q.push_back({2'b01, 8'h22});
`ifdef CMD_FIFO_EN
      exp_q.push_back({2'b01, 8'h33});
`endif
      ready_hi = 1'b1;
      drain("bp");
      check("bp_desc_sticky", descartado, EXP_DROP);

      // Reset mid-operation with key0 held down
      ready_hi = 1'b0;
      sw = 10'h044;
      step(4);
      key_n[0] = 1'b0;
      step(12);
      check("mid_valid", cmd_valid, 1);
      sw = 10'h06C;
      step(3);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_valid", cmd_valid, 0);
      check("mid_rst_tipo", cmd_tipo, 0);
      check("mid_rst_dado", cmd_dado, 0);
      check("mid_rst_desc", descartado, 0);
      step(2);
      got.delete();
      rst = 1'b0;
      ready_hi = 1'b1;
      step(15);
      key_n[0] = 1'b1;
      step(10);
      exp_q.push_back({2'b01, 8'h6C});
      drain("mid_rst");

      // Randomized single actions with random backpressure
      ready_hi   = 1'b0;
      ready_rand = 1'b1;
      for (int n = 0; n < 16; n++) begin
         stim = 10'($urandom) & 10'h0FF;
         sw = stim;
         step(4);
         act = int'($urandom_range(0, 3));
         case (act)
            0: begin
               press(0, int'($urandom_range(6, 12)));
               exp_q.push_back({2'b01, stim[7:0]});
            end
            1: begin
               press(1, int'($urandom_range(6, 12)));
               exp_q.push_back({2'b10, 5'b0, stim[2:0]});
            end
            2: begin
               press(2, int'($urandom_range(6, 12)));
               exp_q.push_back({2'b11, 8'h00});
            end
            default: glitch(int'($urandom_range(0, 2)), int'($urandom_range(1, DB - 1)));
         endcase
         drain("rand");
      end
      check("final_desc", descartado, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
